// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused across W bit positions, LSB first,
// with operand/result valid-ready handshakes and carry-out / signed-overflow reporting.
module serial_adder_ctrl #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         ovf_o,
  output logic         busy_o
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t         state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic           carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           bit_s;
  logic           carry_nxt_s;
  logic           accept_s;

  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign accept_s    = in_valid_i && in_ready_o;
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = busy_q;

  // Next-state and datapath: one full-adder evaluation per RUN cycle on the shift-register LSBs
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    bit_s       = fa_sum(a_sh_q[0], b_sh_q[0], carry_q);
    carry_nxt_s = fa_carry(a_sh_q[0], b_sh_q[0], carry_q);

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          carry_d = cin_i;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[cnt_q] = bit_s;
        carry_d      = carry_nxt_s;
        a_sh_d       = {1'b0, a_sh_q[W-1:1]};
        b_sh_d       = {1'b0, b_sh_q[W-1:1]};
        // carry_q here is the carry into the MSB, so overflow is its mismatch with the carry out
        if (cnt_q == LAST_BIT) begin
          cout_d      = carry_nxt_s;
          ovf_d       = carry_q ^ carry_nxt_s;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      a_sh_q      <= {W{1'b0}};
      b_sh_q      <= {W{1'b0}};
      carry_q     <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      sum_q       <= {W{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, multi-cycle corner
// sequences and a randomized sweep against a cycle-level protocol/arithmetic reference.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         ovf_o;
  logic         busy_o;

  serial_adder_ctrl #(.W(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .cin_i      (cin_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .sum_o      (sum_o),
    .cout_o     (cout_o),
    .ovf_o      (ovf_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: 0 = waiting for operands, 1 = computing, 2 = holding result
  int           m_state = 0;
  int           m_rem   = 0;
  int           cycle   = 0;
  int           ops_done = 0;
  int           accept_cycles[$];
  logic [W-1:0] p_sum, m_sum;
  logic         p_cout, m_cout, p_ovf, m_ovf;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                  output logic [W-1:0] s, output logic co, output logic ov);
    longint u, sa, sb, tot, smax, smin;
    u    = longint'(a) + longint'(b) + longint'(c);
    s    = u[W-1:0];
    co   = u[W];
    sa   = longint'(a) - (a[W-1] ? (longint'(1) << W) : longint'(0));
    sb   = longint'(b) - (b[W-1] ? (longint'(1) << W) : longint'(0));
    tot  = sa + sb + longint'(c);
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    ov   = (tot > smax) || (tot < smin);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the reference on the inputs seen at the edge, then compare outputs
  task automatic step();
    @(posedge clk);
    cycle++;
    if (rst_i) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: if (in_valid_i) begin
             ref_add(a_i, b_i, cin_i, p_sum, p_cout, p_ovf);
             m_state = 1;
             m_rem   = W;
             accept_cycles.push_back(cycle);
           end
        1: begin
             m_rem--;
             if (m_rem == 0) begin
               m_state = 2;
               m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
             end
           end
        2: if (out_ready_i) begin
             m_state = 0;
             ops_done++;
           end
        default: m_state = 0;
      endcase
    end
    #1;
    check("in_ready",  in_ready_o,  (m_state == 0) && !rst_i);
    check("busy",      busy_o,      m_state == 1);
    check("out_valid", out_valid_o, m_state == 2);
    if (m_state == 2) begin
      check("sum",  sum_o,  m_sum);
      check("cout", cout_o, m_cout);
      check("ovf",  ovf_o,  m_ovf);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    rst_i = 1'b1; in_valid_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; out_ready_i = 1'b0;
    step(); step();
    check("rst_sum", sum_o, 0); check("rst_cout", cout_o, 0); check("rst_ovf", ovf_o, 0);
    check("rst_in_ready", in_ready_o, 0);
    rst_i = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready_o, 1);

    // Directed table with latency check
    for (int i = 0; i < 8; i++) begin
      a_i = vecs[i].a; b_i = vecs[i].b; cin_i = vecs[i].c;
      in_valid_i = 1'b1; out_ready_i = 1'b1;
      step();
      in_valid_i = 1'b0; a_i = ~a_i;
      n = 0;
      while (!out_valid_o && n < 20) begin step(); n++; end
      check("latency", n, W);
      check("tbl_sum", sum_o, vecs[i].s);
      check("tbl_cout", cout_o, vecs[i].co);
      check("tbl_ovf", ovf_o, vecs[i].ov);
      step();
    end

    // Backpressure in DONE
    a_i = 8'h12; b_i = 8'h34; cin_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b0;
    step();
    in_valid_i = 1'b0;
    n = 0;
    while (m_state != 2 && n < 20) begin step(); n++; end
    for (int k = 0; k < 5; k++) begin
      in_valid_i = 1'b1; a_i = 8'($urandom);
      step();
    end
    check("bp_sum", sum_o, 8'h47); check("bp_valid", out_valid_o, 1); check("bp_ready", in_ready_o, 0);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    step();
    check("bp_release_ready", in_ready_o, 1);

    // Reset after the 3rd RUN edge
    a_i = 8'hAA; b_i = 8'h55; cin_i = 1'b1; in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step(); step(); step();
    rst_i = 1'b1;
    step();
    check("abort_sum", sum_o, 0); check("abort_cout", cout_o, 0); check("abort_ovf", ovf_o, 0);
    check("abort_valid", out_valid_o, 0); check("abort_busy", busy_o, 0);
    rst_i = 1'b0;
    #1;
    check("abort_ready", in_ready_o, 1);
    a_i = 8'h01; b_i = 8'h01; cin_i = 1'b0; in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 20) begin step(); n++; end
    check("post_abort_sum", sum_o, 8'h02);
    step();

    // Back-to-back throughput with operand churn during RUN
    accept_cycles.delete();
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    n = 0;
    while (accept_cycles.size() < 3 && n < 60) begin
      a_i = 8'($urandom); b_i = 8'($urandom); cin_i = 1'($urandom);
      step(); n++;
    end
    check("tput_ops", accept_cycles.size(), 3);
    if (accept_cycles.size() == 3) begin
      check("tput_gap1", accept_cycles[1] - accept_cycles[0], W + 2);
      check("tput_gap2", accept_cycles[2] - accept_cycles[1], W + 2);
    end
    in_valid_i = 1'b0;
    n = 0;
    while (m_state != 0 && n < 20) begin a_i = 8'($urandom); step(); n++; end

    // Random sweep
    ops_done = 0;
    n = 0;
    while (ops_done < 1000 && n < 40000) begin
      in_valid_i  = 1'($urandom);
      out_ready_i = 1'($urandom);
      a_i = 8'($urandom); b_i = 8'($urandom); cin_i = 1'($urandom);
      step(); n++;
    end
    check("sweep_ops", ops_done >= 1000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
